// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial add/subtract controller.
// Holds the FSM state encoding and the default operand width.
package serial_add_ctrl_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// 1-bit full-adder cell, purely combinational; zero latency, no backpressure.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract through one full-adder cell; done pulses WIDTH+1 edges after start.
// No backpressure: start is only accepted in IDLE and is dropped while busy.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic             c_msb_in;
    logic             c_fin;
    logic             fa_sum;
    logic             fa_cout;

    fa u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (cy),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (cnt == CNT_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sa       <= '0;
            sb       <= '0;
            res      <= '0;
            cnt      <= '0;
            cy       <= 1'b0;
            c_msb_in <= 1'b0;
            c_fin    <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
                    if (start) begin
                        sa  <= op_a;
                        sb  <= sub ? ~op_b : op_b;
                        cy  <= sub;
                        cnt <= '0;
                    end
                end
                S_RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= {fa_sum, res[WIDTH-1:1]};
                    cy  <= fa_cout;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        c_msb_in <= cy;
                        c_fin    <= fa_cout;
                    end
                end
                S_DONE: begin
                    result <= res;
                    cout   <= c_fin;
                    ovf    <= c_msb_in ^ c_fin;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed checks of serial_add_ctrl against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned result/carry, signed range test for overflow.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] r, output logic c, output logic o);
        int ua, ub, sa_i, sb_i, sr;
        ua   = int'(a);
        ub   = int'(b);
        sa_i = $signed(a);
        sb_i = $signed(b);
        if (s) begin
            r  = W'(ua - ub);
            c  = (ua >= ub);
            sr = sa_i - sb_i;
        end else begin
            r  = W'(ua + ub);
            c  = (ua + ub) > ((1 << W) - 1);
            sr = sa_i + sb_i;
        end
        o = (sr > ((1 << (W - 1)) - 1)) || (sr < -(1 << (W - 1)));
    endtask

    // Entered and left on a falling edge; leaves with done high so a following call is back-to-back.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] er, input logic ec, input logic eo, input bit mid);
        int  edges;
        int  bcyc;
        bit  seen;
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        sub   = 1'($urandom);
        edges = 0;
        bcyc  = 0;
        seen  = 0;
        while (!seen && edges < 40) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
            end else begin
                if (busy) bcyc++;
                if (mid && edges == 3) begin
                    start = 1'b1;
                    op_a  = W'($urandom);
                    op_b  = W'($urandom);
                    sub   = ~s;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                edges++;
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(edges), 32'(W + 1));
        chk("busy_cycles", 32'(bcyc), 32'(W + 1));
        chk("result", 32'(result), 32'(er));
        chk("cout", 32'(cout), 32'(ec));
        chk("ovf", 32'(ovf), 32'(eo));
    endtask

    task automatic pulse_end();
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, er;
        logic         rs, ec, eo;
        int           dcnt;

        rst_n = 1'b0;
        start = 1'b1;
        sub   = 1'b0;
        op_a  = 8'hAA;
        op_b  = 8'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_op_from_reset", 32'(busy), 32'd0);

        do_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 0); pulse_end();
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0); pulse_end();
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0); pulse_end();
        do_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 0); pulse_end();
        do_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0); pulse_end();

        // Mid-run start is ignored; the next op is issued on the done cycle itself.
        do_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1);
        do_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 0); pulse_end();

        op_a  = 8'hC3;
        op_b  = 8'h5A;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        dcnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        do_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0); pulse_end();

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rs, er, ec, eo);
            do_op(ra, rb, rs, er, ec, eo, bit'($urandom_range(1, 0)));
            if ($urandom_range(1, 0) == 0) begin
                pulse_end();
                repeat ($urandom_range(3, 0)) @(negedge clk);
            end
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
